// File: rtl/branch_update_queue_pkg.sv
// Shared branch-unit definitions: PHT geometry, update-entry layout and redirect step.
package branch_update_queue_pkg;

    localparam int unsigned PHT_BITS     = 10;
    localparam int unsigned UPD_ENTRY_W  = 33;
    localparam logic [31:0] REDIRECT_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

    // A not-taken branch with the right direction is correct whatever the target fields hold.
    function automatic logic is_mispredict(
        input logic        valid,
        input logic        pred_taken,
        input logic [31:0] pred_target,
        input logic        taken,
        input logic [31:0] target
    );
        return valid & ((pred_taken != taken) | (taken & (pred_target != target)));
    endfunction

endpackage

// File: rtl/bpu_sync_fifo.sv
// Two-write / one-read synchronous FIFO; the writer must never exceed the free space.
module bpu_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr0_en,
    input  logic [WIDTH-1:0]           i_wr0_data,
    input  logic                       i_wr1_en,
    input  logic [WIDTH-1:0]           i_wr1_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr1_ptr;

    // The second write lands behind the first only when the first is actually used.
    assign w_wr1_ptr = r_wr_ptr + PTR_W'(i_wr0_en);

    always_ff @(posedge clk) begin
        if (i_wr0_en) r_mem[r_wr_ptr]  <= i_wr0_data;
        if (i_wr1_en) r_mem[w_wr1_ptr] <= i_wr1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_wr0_en) + PTR_W'(i_wr1_en);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_rd_en);
            r_count  <= r_count + CNT_W'(i_wr0_en) + CNT_W'(i_wr1_en) - CNT_W'(i_rd_en);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/branch_update_queue.sv
// Dual-port branch resolution: mispredict redirect, statistics and queued PHT training.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res1_valid_i,
    input  logic [31:0]           res1_pc_i,
    input  logic                  res1_pred_taken_i,
    input  logic [31:0]           res1_pred_target_i,
    input  logic                  res1_taken_i,
    input  logic [31:0]           res1_target_i,
    input  logic                  res2_valid_i,
    input  logic [31:0]           res2_pc_i,
    input  logic                  res2_pred_taken_i,
    input  logic [31:0]           res2_pred_target_i,
    input  logic                  res2_taken_i,
    input  logic [31:0]           res2_target_i,
    output logic                  corr_valid_o,
    output logic [31:0]           corr_index_o,
    output logic                  corr_branch_flag_o,
    output logic                  redirect_valid_o,
    output logic [31:0]           redirect_pc_o,
    output logic [31:0]           mispred_cnt_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned SPACE_W = CNT_W + 1;
    localparam int unsigned DSUM_W  = DROP_CNT_W + 1;

    logic                   w_mp1;
    logic                   w_mp2;
    logic                   w_v2;
    logic                   w_empty;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_count;
    logic [SPACE_W-1:0]     w_space;
    logic [SPACE_W-1:0]     w_need2;
    logic                   w_acc1;
    logic                   w_acc2;
    logic [1:0]             w_drops;
    logic [DSUM_W-1:0]      w_drop_sum;
    upd_entry_t             w_wr0_data;
    upd_entry_t             w_wr1_data;
    logic [UPD_ENTRY_W-1:0] w_rd_data;
    upd_entry_t             w_head;

    logic                   r_redirect_valid;
    logic [31:0]            r_redirect_pc;
    logic [31:0]            r_mispred_cnt;
    logic [DROP_CNT_W-1:0]  r_drop_cnt;

    // A port1 mispredict puts port2 on the wrong path, so it is dropped from every path below.
    assign w_mp1 = is_mispredict(res1_valid_i, res1_pred_taken_i, res1_pred_target_i,
                                 res1_taken_i, res1_target_i);
    assign w_mp2 = is_mispredict(res2_valid_i, res2_pred_taken_i, res2_pred_target_i,
                                 res2_taken_i, res2_target_i) & ~w_mp1;
    assign w_v2  = res2_valid_i & ~w_mp1;

    assign w_pop   = ~w_empty;
    assign w_space = SPACE_W'(DEPTH) - SPACE_W'(w_count) + SPACE_W'(w_pop);
    assign w_need2 = w_acc1 ? SPACE_W'(2) : SPACE_W'(1);
    assign w_acc1  = res1_valid_i & (w_space >= SPACE_W'(1));
    assign w_acc2  = w_v2 & (w_space >= w_need2);

    assign w_drops    = {1'b0, res1_valid_i & ~w_acc1} + {1'b0, w_v2 & ~w_acc2};
    assign w_drop_sum = {1'b0, r_drop_cnt} + DSUM_W'(w_drops);

    assign w_wr0_data = '{pc: res1_pc_i, taken: res1_taken_i};
    assign w_wr1_data = '{pc: res2_pc_i, taken: res2_taken_i};

    bpu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UPD_ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .i_wr0_en   (w_acc1),
        .i_wr0_data (w_wr0_data),
        .i_wr1_en   (w_acc2),
        .i_wr1_data (w_wr1_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_data),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign w_head = w_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mispred_cnt    <= '0;
            r_drop_cnt       <= '0;
        end else begin
            r_redirect_valid <= w_mp1 | w_mp2;
            if (w_mp1) begin
                r_redirect_pc <= res1_taken_i ? res1_target_i : res1_pc_i + REDIRECT_INC;
            end else if (w_mp2) begin
                r_redirect_pc <= res2_taken_i ? res2_target_i : res2_pc_i + REDIRECT_INC;
            end
            if (w_mp1 | w_mp2) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
            r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    // Head fields are masked while empty so stale RAM contents never reach the PHT port.
    assign corr_valid_o       = ~w_empty;
    assign corr_index_o       = w_empty ? '0 : w_head.pc;
    assign corr_branch_flag_o = w_empty ? 1'b0 : w_head.taken;
    assign redirect_valid_o   = r_redirect_valid;
    assign redirect_pc_o      = r_redirect_pc;
    assign mispred_cnt_o      = r_mispred_cnt;
    assign drop_cnt_o         = r_drop_cnt;

endmodule
